// File: rtl/sample_link_framer.sv
// sample_link_framer: serialises CHANNELS x DATA_W ADC frames into 7-bit-payload FIFO bytes and deserialises one returned frame into DAC samples.
// Define SAMPLE_LINK_FRAMER_STATS_EN to add saturating TX/RX error and dropped-edge counters.
module sample_link_framer #(
   parameter int DATA_W     = 14,
   parameter int CHANNELS   = 2,
   parameter int LEDCNT_MAX = 7200000
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic [CHANNELS*DATA_W-1:0] adc_data_i,
   input  logic                       adc_data_rdy_i,
   output logic [CHANNELS*DATA_W-1:0] dac_data_o,
   output logic                       dac_data_rdy_o,
   output logic                       fifo_tx_data_rdy_o,
   output logic [7:0]                 fifo_tx_data_o,
   input  logic                       fifo_tx_ok_i,
   input  logic                       fifo_tx_err_i,
   output logic                       fifo_rx_poll_o,
   input  logic                       fifo_rx_data_rdy_i,
   input  logic [7:0]                 fifo_rx_data_i,
   input  logic                       fifo_rx_err_i,
   output logic                       led_txerr_o,
   output logic                       led_rxerr_o
`ifdef SAMPLE_LINK_FRAMER_STATS_EN
   ,
   output logic [15:0]                stat_tx_err_o,
   output logic [15:0]                stat_rx_err_o,
   output logic [15:0]                stat_drop_o
`endif
);
   localparam int NBYTES = (DATA_W + 6) / 7;
   localparam int NB7    = 7 * NBYTES;
   localparam int FRAME  = CHANNELS * NBYTES;
   localparam int FW     = 7 * FRAME;
   localparam int IW     = $clog2(FRAME + 1);
   localparam int LW     = $clog2(LEDCNT_MAX + 1);
   localparam logic [IW-1:0] LAST = IW'(FRAME - 1);

   typedef enum logic [2:0] {IDLE, TX_REQ, TX_WAIT, RX_REQ, RX_WAIT, DONE} state_t;

   state_t                     state_q, state_d;
   logic [IW-1:0]              idx_q;
   logic                       adc_q, adc_qq, tx_mark_q;
   logic [FW-1:0]              tx_sr_q, shadow_q, pad, sh_n;
   logic [CHANNELS*DATA_W-1:0] dac_q, dac_n;
   logic [LW-1:0]              txcnt_q, rxcnt_q;
   logic                       rise, last, mark_ok, rx_ok, tx_err_ev, rx_err_ev;

   assign rise      = adc_q & ~adc_qq;
   assign last      = idx_q == LAST;
   assign mark_ok   = fifo_rx_data_i[7] == (idx_q == '0);
   assign rx_ok     = state_q == RX_WAIT && fifo_rx_data_rdy_i && mark_ok;
   assign tx_err_ev = state_q == TX_WAIT && !fifo_tx_ok_i && fifo_tx_err_i;
   assign rx_err_ev = state_q == RX_WAIT && (fifo_rx_data_rdy_i ? !mark_ok : fifo_rx_err_i && idx_q != '0);
   assign sh_n      = (shadow_q << 7) | FW'(fifo_rx_data_i[6:0]);

   // Channel 0 sits at the top of the padded frame so both directions shift MSB-first
   always_comb begin
      pad   = '0;
      dac_n = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         pad[(CHANNELS-1-c)*NB7 +: NB7] = NB7'(adc_data_i[c*DATA_W +: DATA_W]);
         dac_n[c*DATA_W +: DATA_W]      = sh_n[(CHANNELS-1-c)*NB7 +: DATA_W];
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) state_q <= IDLE;
      else           state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise) state_d = TX_REQ;
         TX_REQ:  state_d = TX_WAIT;
         TX_WAIT: if (fifo_tx_ok_i) state_d = last ? RX_REQ : TX_REQ;
                  else if (fifo_tx_err_i) state_d = RX_REQ;
         RX_REQ:  state_d = RX_WAIT;
         RX_WAIT: if (fifo_rx_data_rdy_i) state_d = !mark_ok ? IDLE : last ? DONE : RX_REQ;
                  else if (fifo_rx_err_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fifo_tx_data_rdy_o = state_q == TX_REQ;
      fifo_rx_poll_o     = state_q == RX_REQ;
      dac_data_rdy_o     = state_q == DONE;
      fifo_tx_data_o     = {tx_mark_q, tx_sr_q[FW-1 -: 7]};
      dac_data_o         = dac_q;
      led_txerr_o        = txcnt_q != '0;
      led_rxerr_o        = rxcnt_q != '0;
   end

   // The final byte loads dac_q directly so the data is valid during the DONE pulse
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) begin
         adc_q     <= 1'b0;
         adc_qq    <= 1'b0;
         idx_q     <= '0;
         tx_sr_q   <= '0;
         tx_mark_q <= 1'b0;
         shadow_q  <= '0;
         dac_q     <= '0;
         txcnt_q   <= '0;
         rxcnt_q   <= '0;
      end else begin
         adc_q  <= adc_data_rdy_i;
         adc_qq <= adc_q;
         idx_q  <= (state_d == IDLE || (state_q == TX_WAIT && state_d == RX_REQ)) ? '0 :
                   ((state_q == TX_WAIT && state_d == TX_REQ) || (state_q == RX_WAIT && state_d == RX_REQ)) ? idx_q + IW'(1) : idx_q;
         if (state_q == IDLE && rise) begin
            tx_sr_q   <= pad;
            tx_mark_q <= 1'b1;
         end else if (state_q == TX_WAIT && fifo_tx_ok_i && !last) begin
            tx_sr_q   <= tx_sr_q << 7;
            tx_mark_q <= 1'b0;
         end
         if (rx_ok) shadow_q <= sh_n;
         if (rx_ok && last) dac_q <= dac_n;
         txcnt_q <= tx_err_ev ? LW'(LEDCNT_MAX) : txcnt_q - LW'(txcnt_q != '0);
         rxcnt_q <= rx_err_ev ? LW'(LEDCNT_MAX) : rxcnt_q - LW'(rxcnt_q != '0);
      end

`ifdef SAMPLE_LINK_FRAMER_STATS_EN
   always_ff @(posedge clk_i or negedge reset_ni)
      if (!reset_ni) begin
         stat_tx_err_o <= '0;
         stat_rx_err_o <= '0;
         stat_drop_o   <= '0;
      end else begin
         if (tx_err_ev && stat_tx_err_o != 16'hFFFF) stat_tx_err_o <= stat_tx_err_o + 16'd1;
         if (rx_err_ev && stat_rx_err_o != 16'hFFFF) stat_rx_err_o <= stat_rx_err_o + 16'd1;
         if (rise && state_q != IDLE && stat_drop_o != 16'hFFFF) stat_drop_o <= stat_drop_o + 16'd1;
      end
`endif
endmodule

// File: tb/tb_sample_link_framer.sv
// tb_sample_link_framer: directed checks of a 2x14-bit and a 1x16-bit framer with a short LED hold time.
module tb_sample_link_framer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   logic [27:0] a_adc, a_dac;
   logic        a_adc_rdy, a_dac_rdy, a_txr, a_ok, a_err, a_poll, a_rxr, a_rxe, a_ledt, a_ledr;
   logic [7:0]  a_txd, a_rxd;
   logic [15:0] b_adc, b_dac;
   logic        b_adc_rdy, b_dac_rdy, b_txr, b_ok, b_err, b_poll, b_rxr, b_rxe, b_ledt, b_ledr;
   logic [7:0]  b_txd, b_rxd;

   sample_link_framer #(.DATA_W(14), .CHANNELS(2), .LEDCNT_MAX(10)) u_a (
      .clk_i(clk), .reset_ni(rst_n), .adc_data_i(a_adc), .adc_data_rdy_i(a_adc_rdy),
      .dac_data_o(a_dac), .dac_data_rdy_o(a_dac_rdy), .fifo_tx_data_rdy_o(a_txr), .fifo_tx_data_o(a_txd),
      .fifo_tx_ok_i(a_ok), .fifo_tx_err_i(a_err), .fifo_rx_poll_o(a_poll), .fifo_rx_data_rdy_i(a_rxr),
      .fifo_rx_data_i(a_rxd), .fifo_rx_err_i(a_rxe), .led_txerr_o(a_ledt), .led_rxerr_o(a_ledr));

   sample_link_framer #(.DATA_W(16), .CHANNELS(1), .LEDCNT_MAX(10)) u_b (
      .clk_i(clk), .reset_ni(rst_n), .adc_data_i(b_adc), .adc_data_rdy_i(b_adc_rdy),
      .dac_data_o(b_dac), .dac_data_rdy_o(b_dac_rdy), .fifo_tx_data_rdy_o(b_txr), .fifo_tx_data_o(b_txd),
      .fifo_tx_ok_i(b_ok), .fifo_tx_err_i(b_err), .fifo_rx_poll_o(b_poll), .fifo_rx_data_rdy_i(b_rxr),
      .fifo_rx_data_i(b_rxd), .fifo_rx_err_i(b_rxe), .led_txerr_o(b_ledt), .led_rxerr_o(b_ledr));

   // Host-side TX responder for DUT A: acks every byte, error on byte err_at, until RX polling starts
   task automatic a_host_tx(input int err_at, output int nsent);
      int t = 0;
      nsent = 0;
      while (a_poll !== 1'b1 && t < 60) begin
         if (a_txr === 1'b1) begin
            @(negedge clk);
            a_ok  = nsent != err_at;
            a_err = nsent == err_at;
            nsent++;
            @(negedge clk);
            a_ok  = 1'b0;
            a_err = 1'b0;
         end else begin
            @(negedge clk);
            t++;
         end
      end
   endtask

   task automatic test_reset;
      {a_adc, a_adc_rdy, a_ok, a_err, a_rxr, a_rxd, a_rxe} = '0;
      {b_adc, b_adc_rdy, b_ok, b_err, b_rxr, b_rxd, b_rxe} = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({a_txr, a_txd, a_poll, a_dac_rdy, a_dac, a_ledt, a_ledr} !== 41'd0) begin
         n_fail++;
         $display("FAIL reset_a: outputs %h required 0", {a_txr, a_txd, a_poll, a_dac_rdy, a_dac, a_ledt, a_ledr});
      end
      n_chk++;
      if ({b_txr, b_txd, b_poll, b_dac_rdy, b_dac, b_ledt, b_ledr} !== 29'd0) begin
         n_fail++;
         $display("FAIL reset_b: outputs %h required 0", {b_txr, b_txd, b_poll, b_dac_rdy, b_dac, b_ledt, b_ledr});
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({a_txr, a_poll, b_txr, b_poll} !== 4'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset: req %b required 0000", {a_txr, a_poll, b_txr, b_poll});
      end
   endtask

   task automatic test_tx_encode;
      logic [31:0] exp = 32'hD53C0223;
      int t;
      a_adc = {14'h0123, 14'h2ABC};
      a_adc_rdy = 1'b1;
      @(negedge clk);
      n_chk++;
      if (a_txr !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_latency_early: rdy %b required 0", a_txr);
      end
      @(negedge clk);
      n_chk++;
      if (a_txr !== 1'b1) begin
         n_fail++;
         $display("FAIL tx_latency: rdy %b required 1", a_txr);
      end
      a_adc_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         t = 0;
         while (a_txr !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         n_chk++;
         if (a_txr !== 1'b1 || a_txd !== exp[31-8*i -: 8]) begin
            n_fail++;
            $display("FAIL tx_byte%0d: rdy %b data %h required 1 %h", i, a_txr, a_txd, exp[31-8*i -: 8]);
         end
         @(negedge clk);
         n_chk++;
         if (a_txr !== 1'b0 || a_txd !== exp[31-8*i -: 8]) begin
            n_fail++;
            $display("FAIL tx_pulse%0d: rdy %b data %h required 0 %h", i, a_txr, a_txd, exp[31-8*i -: 8]);
         end
         a_ok = 1'b1;
         @(negedge clk);
         a_ok = 1'b0;
      end
      n_chk++;
      if (a_poll !== 1'b1 || a_txr !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_poll_start: poll %b rdy %b required 1 0", a_poll, a_txr);
      end
   endtask

   task automatic test_rx_decode;
      logic [31:0] rx = 32'h817F0001;
      int t;
      for (int i = 0; i < 4; i++) begin
         t = 0;
         while (a_poll !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         n_chk++;
         if (a_poll !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_poll%0d: poll %b required 1", i, a_poll);
         end
         @(negedge clk);
         a_rxr = 1'b1;
         a_rxd = rx[31-8*i -: 8];
         a_rxe = i == 2;
         @(negedge clk);
         a_rxr = 1'b0;
         a_rxe = 1'b0;
         if (i < 3) begin
            n_chk++;
            if (a_dac_rdy !== 1'b0) begin
               n_fail++;
               $display("FAIL dac_early%0d: rdy %b required 0", i, a_dac_rdy);
            end
         end
      end
      n_chk++;
      if (a_dac_rdy !== 1'b1 || a_dac !== {14'h0001, 14'h00FF}) begin
         n_fail++;
         $display("FAIL dac_frame: rdy %b data %h required 1 %h", a_dac_rdy, a_dac, {14'h0001, 14'h00FF});
      end
      @(negedge clk);
      n_chk++;
      if (a_dac_rdy !== 1'b0 || a_dac !== {14'h0001, 14'h00FF} || a_ledr !== 1'b0) begin
         n_fail++;
         $display("FAIL dac_pulse: rdy %b data %h led %b required 0 %h 0", a_dac_rdy, a_dac, a_ledr, {14'h0001, 14'h00FF});
      end
   endtask

   task automatic test_rx_bad_marker;
      int nsent, cnt = 0, bad = 0;
      a_adc = 28'hFFFFFFF;
      a_adc_rdy = 1'b1;
      @(negedge clk);
      a_adc_rdy = 1'b0;
      a_host_tx(-1, nsent);
      n_chk++;
      if (nsent != 4 || a_poll !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_tx_count: sent %0d poll %b required 4 1", nsent, a_poll);
      end
      @(negedge clk);
      a_rxr = 1'b1;
      a_rxd = 8'h81;
      @(negedge clk);
      a_rxr = 1'b0;
      n_chk++;
      if (a_poll !== 1'b1 || a_ledr !== 1'b0) begin
         n_fail++;
         $display("FAIL bad_first_ok: poll %b led %b required 1 0", a_poll, a_ledr);
      end
      @(negedge clk);
      a_rxr = 1'b1;
      a_rxd = 8'h80;
      @(negedge clk);
      a_rxr = 1'b0;
      for (int k = 0; k < 15; k++) begin
         if (a_ledr === 1'b1) cnt++;
         if (a_dac_rdy !== 1'b0 || a_poll !== 1'b0 || a_txr !== 1'b0) bad++;
         @(negedge clk);
      end
      n_chk++;
      if (cnt != 10) begin
         n_fail++;
         $display("FAIL rxerr_led_len: high %0d cycles required 10", cnt);
      end
      n_chk++;
      if (bad != 0 || a_dac !== {14'h0001, 14'h00FF}) begin
         n_fail++;
         $display("FAIL bad_marker_idle: activity %0d dac %h required 0 %h", bad, a_dac, {14'h0001, 14'h00FF});
      end
   endtask

   task automatic test_tx_err;
      int t = 0, act = 0;
      a_adc = {14'h3FFF, 14'h0000};
      a_adc_rdy = 1'b1;
      @(negedge clk);
      a_adc_rdy = 1'b0;
      while (a_txr !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (a_txr !== 1'b1 || a_txd !== 8'h80) begin
         n_fail++;
         $display("FAIL txerr_byte0: rdy %b data %h required 1 80", a_txr, a_txd);
      end
      @(negedge clk);
      a_ok = 1'b1;
      a_err = 1'b1;
      @(negedge clk);
      a_ok = 1'b0;
      a_err = 1'b0;
      n_chk++;
      if (a_txr !== 1'b1 || a_txd !== 8'h00 || a_ledt !== 1'b0) begin
         n_fail++;
         $display("FAIL ok_wins: rdy %b data %h led %b required 1 00 0", a_txr, a_txd, a_ledt);
      end
      @(negedge clk);
      a_err = 1'b1;
      @(negedge clk);
      a_err = 1'b0;
      n_chk++;
      if (a_poll !== 1'b1 || a_txr !== 1'b0 || a_ledt !== 1'b1) begin
         n_fail++;
         $display("FAIL txerr_abort: poll %b rdy %b led %b required 1 0 1", a_poll, a_txr, a_ledt);
      end
      @(negedge clk);
      a_rxe = 1'b1;
      @(negedge clk);
      a_rxe = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (a_txr !== 1'b0 || a_poll !== 1'b0 || a_ledr !== 1'b0) act++;
         @(negedge clk);
      end
      n_chk++;
      if (act != 0) begin
         n_fail++;
         $display("FAIL rx_empty_idle: %0d active cycles required 0", act);
      end
      n_chk++;
      if (a_ledt !== 1'b0) begin
         n_fail++;
         $display("FAIL txerr_led_expire: led %b required 0", a_ledt);
      end
   endtask

   task automatic test_wide_sample;
      logic [23:0] exp = 24'h837F7F;
      logic [23:0] rx = 24'hFF0005;
      int t, act = 0;
      b_adc = 16'hFFFF;
      b_adc_rdy = 1'b1;
      @(negedge clk);
      b_adc_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         t = 0;
         while (b_txr !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         n_chk++;
         if (b_txr !== 1'b1 || b_txd !== exp[23-8*i -: 8]) begin
            n_fail++;
            $display("FAIL wide_byte%0d: rdy %b data %h required 1 %h", i, b_txr, b_txd, exp[23-8*i -: 8]);
         end
         b_adc_rdy = i == 0;
         @(negedge clk);
         b_ok = 1'b1;
         @(negedge clk);
         b_ok = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         t = 0;
         while (b_poll !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
         end
         n_chk++;
         if (b_poll !== 1'b1) begin
            n_fail++;
            $display("FAIL wide_poll%0d: poll %b required 1", i, b_poll);
         end
         @(negedge clk);
         b_rxr = 1'b1;
         b_rxd = rx[23-8*i -: 8];
         @(negedge clk);
         b_rxr = 1'b0;
      end
      n_chk++;
      if (b_dac_rdy !== 1'b1 || b_dac !== 16'hC005) begin
         n_fail++;
         $display("FAIL wide_dac: rdy %b data %h required 1 c005", b_dac_rdy, b_dac);
      end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (b_txr !== 1'b0) act++;
      end
      n_chk++;
      if (act != 0) begin
         n_fail++;
         $display("FAIL drop_edge: %0d tx requests required 0", act);
      end
   endtask

   task automatic test_async_reset;
      int t = 0;
      b_adc_rdy = 1'b1;
      @(negedge clk);
      b_adc_rdy = 1'b0;
      while (b_txr !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      b_err = 1'b1;
      @(negedge clk);
      b_err = 1'b0;
      n_chk++;
      if (b_poll !== 1'b1 || b_ledt !== 1'b1 || b_txd !== 8'h83) begin
         n_fail++;
         $display("FAIL pre_reset: poll %b led %b data %h required 1 1 83", b_poll, b_ledt, b_txd);
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({b_txr, b_txd, b_poll, b_dac_rdy, b_dac, b_ledt, b_ledr} !== 29'd0) begin
         n_fail++;
         $display("FAIL async_reset_b: outputs %h required 0", {b_txr, b_txd, b_poll, b_dac_rdy, b_dac, b_ledt, b_ledr});
      end
      n_chk++;
      if (a_dac !== 28'd0) begin
         n_fail++;
         $display("FAIL async_reset_a: dac %h required 0", a_dac);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({b_txr, b_poll, b_ledt} !== 3'd0) begin
         n_fail++;
         $display("FAIL post_reset_idle: %b required 000", {b_txr, b_poll, b_ledt});
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_tx_encode();
      test_rx_decode();
      test_rx_bad_marker();
      test_tx_err();
      test_wide_sample();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sample_link_framer.md
Name: sample_link_framer

Overview:
- Parametrised successor of the single-channel 14-bit ADC/DAC host link.
- Serialises a multi-channel ADC sample frame into 7-bit-payload bytes toward the FT2232H byte FIFO interface, then polls the FIFO and deserialises one frame back into multi-channel DAC samples.
- Sits between the ADC/DAC cores and an externally instantiated fifo_interface. Also drives TX/RX error LEDs.

Parameters:
- DATA_W, 14, sample width per channel in bits (1..28).
- CHANNELS, 2, samples per frame (1..8).
- LEDCNT_MAX, 7200000, error-LED hold time in clk_i cycles.

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  reset; asynchronous, active-low.
- adc_data_i  in  CHANNELS*DATA_W  ADC samples; channel c at [c*DATA_W +: DATA_W].
- adc_data_rdy_i  in  1  new-frame strobe; the rising edge is used.
- dac_data_o  out  CHANNELS*DATA_W  last complete received frame, same packing as adc_data_i.
- dac_data_rdy_o  out  1  one-cycle pulse when dac_data_o updates.
- fifo_tx_data_rdy_o  out  1  one-cycle byte-send request.
- fifo_tx_data_o  out  8  byte to send.
- fifo_tx_ok_i  in  1  byte sent.
- fifo_tx_err_i  in  1  byte send failed.
- fifo_rx_poll_o  out  1  one-cycle byte-read request.
- fifo_rx_data_rdy_i  in  1  received byte valid.
- fifo_rx_data_i  in  8  received byte.
- fifo_rx_err_i  in  1  read failed or FIFO empty.
- led_txerr_o  out  1  TX error indicator.
- led_rxerr_o  out  1  RX error indicator.

Behaviour:
- **Frame encoding**
  - NBYTES = ceil(DATA_W/7); frame = CHANNELS*NBYTES bytes, channel 0 first.
  - Each sample is zero-extended to 7*NBYTES bits and sent MSB-first. Byte k of a sample carries bits [7*(NBYTES-1-k) +: 7] in bits [6:0].
  - Bit 7 = 1 only on frame byte 0; bit 7 = 0 on all other bytes.
- **Reset** (async, all registers): state IDLE, all outputs 0, dac_data_o 0, LED counters 0.
- **States:** IDLE, TX_REQ, TX_WAIT, RX_REQ, RX_WAIT, DONE.
- **IDLE**
  - On adc_data_rdy_i rising edge (edge register also reset), latch adc_data_i, set byte index 0, go to TX_REQ.
  - Edges arriving in any other state are dropped.
- **TX_REQ:** drive fifo_tx_data_o for the current byte, pulse fifo_tx_data_rdy_o for 1 cycle, go to TX_WAIT.
- **TX_WAIT**
  - fifo_tx_ok_i: if last byte, reset index to 0 and go to RX_REQ; otherwise increment index and go to TX_REQ.
  - fifo_tx_err_i: load TX LED counter, abort the remaining bytes, reset index, go to RX_REQ.
  - ok and err in the same cycle: ok wins.
  - fifo_tx_data_o holds its value until the next TX_REQ.
- **RX_REQ:** pulse fifo_rx_poll_o for 1 cycle, go to RX_WAIT.
- **RX_WAIT**
  - fifo_rx_data_rdy_i has priority over fifo_rx_err_i.
  - Valid byte with correct bit 7 (1 at index 0, 0 otherwise): shift bits [6:0] into the shadow sample register. If last byte go to DONE, else increment index and go to RX_REQ.
  - Bit-7 mismatch: load RX LED counter, go to IDLE; dac_data_o unchanged.
  - fifo_rx_err_i at index 0 means no host data pending: return to IDLE silently (no LED).
  - fifo_rx_err_i at index > 0: load RX LED counter, go to IDLE.
- **DONE:** copy shadow to dac_data_o, truncating each channel to DATA_W LSBs (padding bits discarded). Pulse dac_data_rdy_o for 1 cycle, go to IDLE.
- **Latency**
  - ADC edge to first fifo_tx_data_rdy_o: 2 cycles.
  - Last valid RX byte to dac_data_rdy_o: 1 cycle.
- **LED counters**
  - Width ceil(log2(LEDCNT_MAX+1)).
  - Decrement by 1 per cycle, saturating at 0; a load on the same cycle wins.
  - LED output = (counter != 0).

Optional Feature:
- Macro: SAMPLE_LINK_FRAMER_STATS_EN.
- When defined, adds three 16-bit output ports, each saturating at 0xFFFF and cleared on reset:
  - stat_tx_err_o: fifo_tx_err_i events.
  - stat_rx_err_o: RX errors (mismatch, or err at index > 0).
  - stat_drop_o: ADC edges dropped while not in IDLE.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- DATA_W=14, CHANNELS=2, FIFO always ok: adc ch0=0x2ABC, ch1=0x0123 -> tx bytes D5,3C,02,23 in order, each a single-cycle rdy pulse, then fifo_rx_poll_o pulses.
- Same config, rx bytes 81,7F,00,01 -> dac_data_o ch0=0x00FF, ch1=0x0001, single dac_data_rdy_o pulse 1 cycle after the 4th byte.
- rx bytes 81,80 (bad marker on byte 1) -> no dac_data_rdy_o, dac_data_o unchanged, led_rxerr_o high for LEDCNT_MAX cycles (bench LEDCNT_MAX=10), then state returns to IDLE.
- fifo_tx_err_i on byte 1 -> bytes 2,3 not sent, led_txerr_o set, RX polling still starts; fifo_rx_err_i on first poll -> IDLE, led_rxerr_o stays low.
- DATA_W=16, CHANNELS=1: adc=0xFFFF -> bytes 83,7F,7F; 2nd ADC edge during TX dropped; reset_ni asserted mid-frame -> all outputs 0 asynchronously.
